paddle_pot_emu: RTL and testbench
=================================

Name: paddle_pot_emu

Overview:
- Transmitter side of the TIA pot-port interface (INPT0-INPT3).
- Emulates four paddle potentiometer/capacitor RC networks. Each pin's "charged" level rises a number of scanlines after the dump is released; that count is proportional to an 8-bit paddle position.
- Sits between the MiSTer paddle/analog input path and the TIA i0-i3 inputs.
- Driven by the same line timing and the same VBLANK D7 dump control that the TIA core exposes.

Parameters:
- MIN_LINES, 1: scanlines to charge at position 0 (must be >= 1).
- SPAN, 380: additional scanline range across positions 0..255.
- CW, 9: charge counter width. Requires MIN_LINES + SPAN - 1 < 2^CW.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- line_tick  in  1  one-clk pulse per scanline (leading edge of hsync)
- dump  in  1  VBLANK D7; 1 = capacitors grounded
- present  in  4  per-channel paddle connected flag
- pos0..pos3  in  8 each  paddle position; 0 = fastest charge
- inpt  out  4  pot pin levels to TIA i0-i3 (1 = charged)
- charging  out  4  per-channel CHARGING state flag (debug/verification)

Behaviour:
- Per-channel FSM, states DUMPED, CHARGING, CHARGED, plus a CW-bit counter and a CW-bit latched target.
- Reset (async): all channels DUMPED, counter = 0, target = 0, inpt = 0, charging = 0.
- Target computation: target = MIN_LINES + ((pos * SPAN) >> 8).
  - Uses a 17-bit product, truncated after the shift.
  - Latched on the cycle dump is sampled falling (dump_q = 1, dump = 0).
  - pos changes after latching have no effect until the next dump release.
- DUMPED:
  - inpt = 0, counter = 0.
  - On dump release with present = 1 -> CHARGING, counter = 0.
  - On dump release with present = 0 -> stay DUMPED; an unconnected pin never charges.
- CHARGING:
  - On each line_tick: counter <= counter + 1.
  - If counter + 1 >= target -> CHARGED, and inpt <= 1 on that same clock edge (registered; visible the cycle after the tick).
  - Counter saturates at 2^CW - 1 and never wraps. If saturation is reached, force CHARGED.
- CHARGED:
  - inpt = 1; counter holds.
  - Stays CHARGED until dump = 1.
- dump = 1 in any state: next edge -> DUMPED, inpt = 0, counter = 0. dump has priority over a line_tick in the same cycle.
- dump held high continuously: channels stay DUMPED. A release requires a registered 1->0 transition; a rst-to-low start counts as released only after dump has first been seen at 1.
- present deasserted mid-CHARGING or while CHARGED: next edge -> DUMPED, inpt = 0.
- line_tick while dump = 0 and DUMPED: ignored.
- Channels are fully independent; there are no shared counters.
- Output mapping: charging[n] = (state == CHARGING); inpt[n] = (state == CHARGED). No combinational path from inputs to outputs.
- Reset asserted mid-charge: immediate async return to the reset values; the next charge requires a fresh dump release.

Test Plan:
- Reset values: assert rst mid-operation with inpt = 4'b1111 -> inpt = 0 and charging = 0 asynchronously; after deassert, ticks without a dump cycle leave inpt = 0.
- Extremes: pos0 = 0, pos1 = 255, present = 4'b0011, dump 1->0, then line_ticks every 228 clk.
  - inpt[0] rises 1 clk after tick 1.
  - inpt[1] rises 1 clk after tick 379 (1 + 378).
  - inpt[3:2] stay 0 throughout.
- Midpoint and late change: pos2 = 128, present[2] = 1, release dump, then change pos2 to 0 at tick 5 -> inpt[2] rises after tick 191; the change is ignored.
- Mid-charge dump: pos3 = 200, reassert dump at tick 100 while charging[3] = 1 -> inpt[3] = 0 and charging[3] = 0 next edge. Re-release -> full 297 ticks again.
- Simultaneous events: dump and line_tick asserted in the same cycle while counter = target - 1 -> channel goes DUMPED and inpt stays 0.
- Saturation: MIN_LINES = 1, SPAN = 510, CW = 9, pos = 255 -> target = 509; CHARGED after tick 509 with counter = 509, no wrap; extra ticks leave counter = 509 and inpt = 1.

Source files
------------

// File: rtl/paddle_pot_emu.sv
`default_nettype none
// ============================================================================
// Module   : paddle_pot_emu
// Purpose  : Emulates the four paddle potentiometer/capacitor RC networks that
//            feed the TIA pot pins (INPT0-INPT3). After the VBLANK D7 dump is
//            released, each pin reads "charged" a number of scanlines later.
//            That count is MIN_LINES + ((pos * SPAN) >> 8).
// Ports    : clk          system clock
//            rst          asynchronous active-high reset
//            i_line_tick  one-clk pulse per scanline
//            i_dump       VBLANK D7 (1 = capacitors grounded)
//            i_present    per-channel paddle connected flag
//            i_pos0..3    8-bit paddle positions (0 = fastest charge)
//            o_inpt       pot pin levels to TIA i0-i3 (1 = charged)
//            o_charging   per-channel CHARGING state flag
// Revision : 1.0 - initial release
// ============================================================================
module paddle_pot_emu #(
  parameter int MIN_LINES = 1,
  parameter int SPAN      = 380,
  parameter int CW        = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_line_tick,
  input  logic       i_dump,
  input  logic [3:0] i_present,
  input  logic [7:0] i_pos0,
  input  logic [7:0] i_pos1,
  input  logic [7:0] i_pos2,
  input  logic [7:0] i_pos3,
  output logic [3:0] o_inpt,
  output logic [3:0] o_charging
);

  localparam logic [1:0] ST_DUMPED   = 2'd0;
  localparam logic [1:0] ST_CHARGING = 2'd1;
  localparam logic [1:0] ST_CHARGED  = 2'd2;

  localparam logic [16:0]   c_SPAN    = 17'(SPAN);
  localparam logic [CW-1:0] c_MIN     = CW'(MIN_LINES);
  localparam logic [CW-1:0] c_CNT_MAX = '1;
  localparam logic [CW-1:0] c_ONE     = CW'(1);

  logic          r_dump_q;
  logic [1:0]    r_state [4];
  logic [CW-1:0] r_cnt   [4];
  logic [CW-1:0] r_tgt   [4];

  logic [7:0]    w_pos     [4];
  logic [16:0]   w_prod    [4];
  logic [CW-1:0] w_tgt_new [4];
  logic [CW-1:0] w_cnt_inc [4];
  logic          w_release;

  // A release is a registered 1->0 edge of dump. r_dump_q resets to 0 so a
  // start with dump already low is not mistaken for a release.
  assign w_release = r_dump_q & ~i_dump;

  always_comb begin
    w_pos[0] = i_pos0;
    w_pos[1] = i_pos1;
    w_pos[2] = i_pos2;
    w_pos[3] = i_pos3;
    for (int i = 0; i < 4; i++) begin
      // 8x9-bit product fits 17 bits; shift then truncate to counter width.
      w_prod[i]    = {9'd0, w_pos[i]} * c_SPAN;
      w_tgt_new[i] = c_MIN + CW'(w_prod[i] >> 8);
      w_cnt_inc[i] = r_cnt[i] + c_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dump_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_state[i] <= ST_DUMPED;
        r_cnt[i]   <= '0;
        r_tgt[i]   <= '0;
      end
    end else begin
      r_dump_q <= i_dump;
      for (int i = 0; i < 4; i++) begin
        if (i_dump) begin
          // Dump wins over everything, including a same-cycle line tick.
          r_state[i] <= ST_DUMPED;
          r_cnt[i]   <= '0;
        end else begin
          case (r_state[i])
            ST_DUMPED: begin
              r_cnt[i] <= '0;
              if (w_release) begin
                // Position is captured once per release; later moves are
                // ignored until the next dump cycle.
                r_tgt[i] <= w_tgt_new[i];
                if (i_present[i]) begin
                  r_state[i] <= ST_CHARGING;
                end
              end
            end
            ST_CHARGING: begin
              if (!i_present[i]) begin
                r_state[i] <= ST_DUMPED;
                r_cnt[i]   <= '0;
              end else if (i_line_tick) begin
                if (r_cnt[i] == c_CNT_MAX) begin
                  // Saturated: hold count and force the pin high.
                  r_state[i] <= ST_CHARGED;
                end else begin
                  r_cnt[i] <= w_cnt_inc[i];
                  if (w_cnt_inc[i] >= r_tgt[i]) begin
                    r_state[i] <= ST_CHARGED;
                  end
                end
              end
            end
            ST_CHARGED: begin
              if (!i_present[i]) begin
                r_state[i] <= ST_DUMPED;
                r_cnt[i]   <= '0;
              end
            end
            default: begin
              r_state[i] <= ST_DUMPED;
              r_cnt[i]   <= '0;
            end
          endcase
        end
      end
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      o_inpt[i]     = (r_state[i] == ST_CHARGED);
      o_charging[i] = (r_state[i] == ST_CHARGING);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_paddle_pot_emu.sv
`default_nettype none
// ============================================================================
// Module   : tb_paddle_pot_emu
// Purpose  : Directed self-checking bench for paddle_pot_emu. Line ticks are
//            spaced a few clocks apart; charge timing depends only on tick
//            count, not on the clock spacing between ticks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_paddle_pot_emu;

  logic       clk;
  logic       rst;
  logic       line_tick;
  logic       dump;
  logic [3:0] present;
  logic [7:0] pos0, pos1, pos2, pos3;
  logic [3:0] inpt, charging;
  logic [3:0] s_inpt, s_charging;

  int checks   = 0;
  int failures = 0;
  int tick_cnt = 0;
  int rise [4];
  int rise_s   = 0;

  paddle_pot_emu u_dut (
    .clk         (clk),
    .rst         (rst),
    .i_line_tick (line_tick),
    .i_dump      (dump),
    .i_present   (present),
    .i_pos0      (pos0),
    .i_pos1      (pos1),
    .i_pos2      (pos2),
    .i_pos3      (pos3),
    .o_inpt      (inpt),
    .o_charging  (charging)
  );

  // Wider span instance: pos 255 gives target 509 in a 9-bit counter.
  paddle_pot_emu #(.MIN_LINES(1), .SPAN(510), .CW(9)) u_sat (
    .clk         (clk),
    .rst         (rst),
    .i_line_tick (line_tick),
    .i_dump      (dump),
    .i_present   (present),
    .i_pos0      (8'd255),
    .i_pos1      (8'd255),
    .i_pos2      (8'd255),
    .i_pos3      (8'd255),
    .o_inpt      (s_inpt),
    .o_charging  (s_charging)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One line tick; record the first tick after which each pin reads high.
  task automatic do_tick();
    @(negedge clk) line_tick = 1'b1;
    @(negedge clk) line_tick = 1'b0;
    tick_cnt++;
    for (int b = 0; b < 4; b++)
      if (rise[b] == 0 && inpt[b]) rise[b] = tick_cnt;
    if (rise_s == 0 && s_inpt[0]) rise_s = tick_cnt;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_to(input int n);
    while (tick_cnt < n) do_tick();
  endtask

  task automatic do_release();
    @(negedge clk) dump = 1'b1;
    @(negedge clk) dump = 1'b0;
    @(negedge clk);
    tick_cnt = 0;
    rise_s   = 0;
    for (int b = 0; b < 4; b++) rise[b] = 0;
  endtask

  initial begin
    rst = 1'b1; line_tick = 1'b0; dump = 1'b0; present = 4'b0000;
    pos0 = 8'd0; pos1 = 8'd0; pos2 = 8'd0; pos3 = 8'd0;
    for (int b = 0; b < 4; b++) rise[b] = 0;
    #12;
    chk("reset_inpt", {28'd0, inpt}, 32'd0);
    chk("reset_charging", {28'd0, charging}, 32'd0);
    @(negedge clk) rst = 1'b0;

    // Dump low from reset is not a release.
    present = 4'b1111;
    repeat (3) do_tick();
    chk("no_release_inpt", {28'd0, inpt}, 32'd0);
    chk("no_release_charging", {28'd0, charging}, 32'd0);

    // Dump held high keeps everything dumped.
    dump = 1'b1;
    repeat (3) do_tick();
    chk("dump_held_inpt", {28'd0, inpt}, 32'd0);
    chk("dump_held_charging", {28'd0, charging}, 32'd0);

    // Extremes: target 1 and 379; unconnected pins never charge.
    pos0 = 8'd0; pos1 = 8'd255; present = 4'b0011;
    do_release();
    chk("ext_charging", {28'd0, charging}, 32'b0011);
    run_to(400);
    chk("ext_rise0", rise[0], 1);
    chk("ext_rise1", rise[1], 379);
    chk("ext_rise2", rise[2], 0);
    chk("ext_rise3", rise[3], 0);
    chk("ext_inpt", {28'd0, inpt}, 32'b0011);

    // Midpoint with late position change: target 191 latched.
    pos2 = 8'd128; present = 4'b0100;
    do_release();
    run_to(5);
    pos2 = 8'd0;
    run_to(250);
    chk("mid_rise2", rise[2], 191);

    // Mid-charge dump, then full restart: target 297.
    pos3 = 8'd200; present = 4'b1000;
    do_release();
    run_to(100);
    chk("mc_charging", {28'd0, charging}, 32'b1000);
    chk("mc_not_yet", rise[3], 0);
    @(negedge clk) dump = 1'b1;
    @(negedge clk);
    chk("mc_dump_charging", {28'd0, charging}, 32'd0);
    chk("mc_dump_inpt", {28'd0, inpt}, 32'd0);
    do_release();
    run_to(300);
    chk("mc_rise3", rise[3], 297);

    // Dump and tick together at counter = target - 1 (target 2).
    pos3 = 8'd1;
    do_release();
    do_tick();
    chk("sim_pre_inpt", {28'd0, inpt}, 32'd0);
    @(negedge clk) begin dump = 1'b1; line_tick = 1'b1; end
    @(negedge clk) begin line_tick = 1'b0; end
    chk("sim_inpt", {28'd0, inpt}, 32'd0);
    chk("sim_charging", {28'd0, charging}, 32'd0);

    // Present removed mid-charge: dumped, and stays dumped without release.
    pos0 = 8'd255; present = 4'b0001;
    do_release();
    run_to(10);
    present = 4'b0000;
    @(negedge clk);
    chk("pres_charging", {28'd0, charging}, 32'd0);
    present = 4'b0001;
    run_to(20);
    chk("pres_stay_inpt", {28'd0, inpt}, 32'd0);
    chk("pres_stay_charging", {28'd0, charging}, 32'd0);

    // Saturation instance: target 509, count holds afterwards.
    do_release();
    run_to(515);
    chk("sat_rise", rise_s, 509);
    chk("sat_count", {23'd0, u_sat.r_cnt[0]}, 32'd509);
    chk("sat_inpt", {31'd0, s_inpt[0]}, 32'd1);

    // Async reset mid-operation.
    pos0 = 8'd0; pos1 = 8'd0; pos2 = 8'd0; pos3 = 8'd0; present = 4'b1111;
    do_release();
    do_tick();
    chk("rst_pre_inpt", {28'd0, inpt}, 32'b1111);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_inpt", {28'd0, inpt}, 32'd0);
    chk("rst_async_charging", {28'd0, charging}, 32'd0);
    @(negedge clk) rst = 1'b0;
    tick_cnt = 0;
    run_to(3);
    chk("rst_after_inpt", {28'd0, inpt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
